microwave_countdown_timer: RTL and testbench

Consumer of the divided clock: takes the slow tick square wave from the frequency divider and counts the microwave cook time down in BCD minutes:seconds. Provides load/start/pause/clear control and signals completion. Sits between the keypad/control FSM and the display driver.

---
 rtl/microwave_countdown_timer.sv | 169 ++++++++++++++++
 tb/tb_microwave_countdown_timer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_countdown_timer.sv
// Microwave countdown timer: counts a BCD mm:ss cook time down once per
// TICKS_PER_SECOND synchronised rising edges of tick_in, with load/start/
// pause/clear control and one-cycle done / load_error pulses.
// Optional door interlock is compiled in with `define DOOR_INTERLOCK_EN.
module microwave_countdown_timer #(
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned TICKS_PER_SECOND = 1
) (
    input  logic       in_clock,
    input  logic       reset_n,
    input  logic       tick_in,
`ifdef DOOR_INTERLOCK_EN
    input  logic       door_open,
`endif
    input  logic       load,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [7:0] mm_bcd,
    output logic [7:0] ss_bcd,
    output logic       running,
    output logic       done,
    output logic       load_error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOADED,
        ST_RUNNING,
        ST_PAUSED,
        ST_DONE
    } state_t;

    localparam logic [7:0] PRESC_LAST = 8'(TICKS_PER_SECOND - 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] tick_sync_q, tick_sync_d;
    logic                   tick_prev_q, tick_prev_d;
    logic [7:0]             presc_q, presc_d;
    logic [15:0]            time_q, time_d;
    logic                   done_q, done_d;
    logic                   load_error_q, load_error_d;

    logic                   tick_rise;
    logic                   in_run;
    logic                   sec_pulse;
    logic                   load_ok;
    logic                   door_hi;
    logic [15:0]            time_dec;

`ifdef DOOR_INTERLOCK_EN
    logic [SYNC_STAGES-1:0] door_sync_q, door_sync_d;

    // Door level synchroniser
    always_ff @(posedge in_clock or negedge reset_n) begin
        if (!reset_n) door_sync_q <= '0;
        else          door_sync_q <= door_sync_d;
    end

    assign door_sync_d = {door_sync_q[SYNC_STAGES-2:0], door_open};
    assign door_hi     = door_sync_q[SYNC_STAGES-1];
`else
    assign door_hi = 1'b0;
`endif

    // One-step BCD decrement of {mm, ss}; saturates at 00:00
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (t != 16'h0000) begin
            if (so != 4'd0) begin
                so = so - 4'd1;
            end else begin
                so = 4'd9;
                if (st != 4'd0) begin
                    st = st - 4'd1;
                end else begin
                    st = 4'd5;
                    if (mo != 4'd0) begin
                        mo = mo - 4'd1;
                    end else begin
                        mo = 4'd9;
                        mt = mt - 4'd1;
                    end
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    assign tick_sync_d = {tick_sync_q[SYNC_STAGES-2:0], tick_in};
    assign tick_prev_d = tick_sync_q[SYNC_STAGES-1];
    assign tick_rise   = tick_sync_q[SYNC_STAGES-1] & ~tick_prev_q;
    assign in_run      = (state_q == ST_RUNNING);
    assign sec_pulse   = in_run && tick_rise && (presc_q == PRESC_LAST);
    assign time_dec    = bcd_dec(time_q);
    assign load_ok     = (load_mm[7:4] <= 4'd9) && (load_mm[3:0] <= 4'd9) &&
                         (load_ss[7:4] <= 4'd5) && (load_ss[3:0] <= 4'd9);

    // State, time and prescaler registers
    always_ff @(posedge in_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            tick_sync_q  <= '0;
            tick_prev_q  <= 1'b0;
            presc_q      <= '0;
            time_q       <= '0;
            done_q       <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_sync_q  <= tick_sync_d;
            tick_prev_q  <= tick_prev_d;
            presc_q      <= presc_d;
            time_q       <= time_d;
            done_q       <= done_d;
            load_error_q <= load_error_d;
        end
    end

    // Next-state logic; strobe priority clear > load > pause > start, and a
    // strobe that acts in a cycle suppresses that cycle's second tick
    always_comb begin
        state_d      = state_q;
        time_d       = time_q;
        presc_d      = presc_q;
        done_d       = 1'b0;
        load_error_d = 1'b0;

        if (clear) begin
            state_d = ST_IDLE;
            time_d  = '0;
            presc_d = '0;
        end else if (load && !in_run) begin
            if (load_ok) begin
                state_d = ST_LOADED;
                time_d  = {load_mm, load_ss};
                presc_d = '0;
            end else begin
                load_error_d = 1'b1;
            end
        end else if (in_run && (pause || door_hi)) begin
            state_d = ST_PAUSED;
        end else if (start && !door_hi && (time_q != 16'h0000) &&
                     ((state_q == ST_LOADED) || (state_q == ST_PAUSED))) begin
            state_d = ST_RUNNING;
        end else if (in_run && tick_rise) begin
            if (sec_pulse) begin
                presc_d = '0;
                time_d  = time_dec;
                if (time_dec == 16'h0000) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end else begin
                presc_d = presc_q + 8'd1;
            end
        end
    end

    assign mm_bcd     = time_q[15:8];
    assign ss_bcd     = time_q[7:0];
    assign running    = in_run;
    assign done       = done_q;
    assign load_error = load_error_q;

endmodule

// File: tb/tb_microwave_countdown_timer.sv
// Bench for microwave_countdown_timer: dut0 (TICKS_PER_SECOND=1) and
// dut1 (TICKS_PER_SECOND=3). Every change of a DUT's output tuple is
// matched in order against a per-DUT queue of expected tuples.
module tb_microwave_countdown_timer;

    typedef struct packed {
        logic [7:0] mm;
        logic [7:0] ss;
        logic       run;
        logic       done;
        logic       lerr;
    } obs_t;

    typedef struct {
        obs_t o;
        int   cyc;
    } exp_t;

    localparam logic [3:0] M_LOAD  = 4'b0001;
    localparam logic [3:0] M_START = 4'b0010;
    localparam logic [3:0] M_PAUSE = 4'b0100;
    localparam logic [3:0] M_CLEAR = 4'b1000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] tick_s = '0, load_s = '0, start_s = '0, pause_s = '0, clear_s = '0;
    logic [7:0] lmm_s [2];
    logic [7:0] lss_s [2];
    logic [7:0] mm_o [2];
    logic [7:0] ss_o [2];
    logic [1:0] run_o, done_o, lerr_o;
`ifdef DOOR_INTERLOCK_EN
    logic       door_s = 1'b0;
`endif

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    obs_t prev [2];
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    microwave_countdown_timer #(.SYNC_STAGES(2), .TICKS_PER_SECOND(1)) dut0 (
        .in_clock(clk), .reset_n(reset_n), .tick_in(tick_s[0]),
`ifdef DOOR_INTERLOCK_EN
        .door_open(door_s),
`endif
        .load(load_s[0]), .load_mm(lmm_s[0]), .load_ss(lss_s[0]),
        .start(start_s[0]), .pause(pause_s[0]), .clear(clear_s[0]),
        .mm_bcd(mm_o[0]), .ss_bcd(ss_o[0]), .running(run_o[0]),
        .done(done_o[0]), .load_error(lerr_o[0])
    );

    microwave_countdown_timer #(.SYNC_STAGES(2), .TICKS_PER_SECOND(3)) dut1 (
        .in_clock(clk), .reset_n(reset_n), .tick_in(tick_s[1]),
`ifdef DOOR_INTERLOCK_EN
        .door_open(door_s),
`endif
        .load(load_s[1]), .load_mm(lmm_s[1]), .load_ss(lss_s[1]),
        .start(start_s[1]), .pause(pause_s[1]), .clear(clear_s[1]),
        .mm_bcd(mm_o[1]), .ss_bcd(ss_o[1]), .running(run_o[1]),
        .done(done_o[1]), .load_error(lerr_o[1])
    );

    function automatic obs_t o(input logic [7:0] mm, input logic [7:0] ss,
                               input logic r, input logic dn, input logic le);
        return {mm, ss, r, dn, le};
    endfunction

    function automatic obs_t get_obs(input int i);
        return {mm_o[i], ss_o[i], run_o[i], done_o[i], lerr_o[i]};
    endfunction

    // Queue an expected tuple; pulse outputs also queue their fall one cycle later
    task automatic push_evt(input int d, input obs_t e, input int c);
        exp_t x;
        x.o = e;
        x.cyc = c;
        if (d == 0) q0.push_back(x); else q1.push_back(x);
        if (e.done || e.lerr) begin
            x.o.done = 1'b0;
            x.o.lerr = 1'b0;
            x.cyc = (c < 0) ? -1 : c + 1;
            if (d == 0) q0.push_back(x); else q1.push_back(x);
        end
    endtask

    task automatic check_change(input int i, input obs_t cur);
        exp_t x;
        n_cmp++;
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            n_bad++;
            $display("FAIL unexpected_change dut%0d cyc=%0d: got %h:%h run=%b done=%b lerr=%b, required no change",
                     i, cyc, cur.mm, cur.ss, cur.run, cur.done, cur.lerr);
        end else begin
            x = (i == 0) ? q0.pop_front() : q1.pop_front();
            if (cur !== x.o || (x.cyc >= 0 && x.cyc != cyc)) begin
                n_bad++;
                $display("FAIL output_tuple dut%0d: got %h:%h run=%b done=%b lerr=%b at cyc %0d, required %h:%h run=%b done=%b lerr=%b at cyc %0d",
                         i, cur.mm, cur.ss, cur.run, cur.done, cur.lerr, cyc,
                         x.o.mm, x.o.ss, x.o.run, x.o.done, x.o.lerr, x.cyc);
            end
        end
    endtask

    // Monitor: any change of a DUT's outputs consumes one expected entry
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                obs_t cur;
                cur = get_obs(i);
                if (cur !== prev[i]) begin
                    check_change(i, cur);
                    prev[i] = cur;
                end
            end
        end
    end

    task automatic set_strobes(input int d, input logic [3:0] m);
        load_s[d]  = m[0];
        start_s[d] = m[1];
        pause_s[d] = m[2];
        clear_s[d] = m[3];
    endtask

    task automatic strobe(input int d, input logic [3:0] m, input logic [7:0] mm,
                          input logic [7:0] ss, input bit ex, input obs_t e);
        @(posedge clk); #1;
        lmm_s[d] = mm;
        lss_s[d] = ss;
        set_strobes(d, m);
        if (ex) push_evt(d, e, cyc + 1);
        @(posedge clk); #1;
        set_strobes(d, 4'b0000);
        repeat (2) @(posedge clk);
    endtask

    // One tick_in pulse; optional strobes land in the cycle its sec_pulse acts
    task automatic tick(input int d, input logic [3:0] m, input bit ex, input obs_t e);
        int r;
        @(posedge clk); #1;
        tick_s[d] = 1'b1;
        r = cyc;
        if (ex) push_evt(d, e, r + 3);
        repeat (2) @(posedge clk); #1;
        set_strobes(d, m);
        @(posedge clk); #1;
        set_strobes(d, 4'b0000);
        repeat (2) @(posedge clk); #1;
        tick_s[d] = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    initial begin
        obs_t z;
        z = o(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            lmm_s[i] = '0;
            lss_s[i] = '0;
        end
        repeat (3) @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (get_obs(i) !== z) begin
                n_bad++;
                $display("FAIL reset_state dut%0d: got %h, required %h", i, get_obs(i), z);
            end
            prev[i] = z;
        end
        #1 reset_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);

        // Asynchronous reset in the middle of a countdown
        strobe(0, M_LOAD, 8'h00, 8'h05, 1, o(8'h00, 8'h05, 0, 0, 0));
        strobe(0, M_START, 8'h00, 8'h00, 1, o(8'h00, 8'h05, 1, 0, 0));
        tick(0, 4'b0, 1, o(8'h00, 8'h04, 1, 0, 0));
        tick(0, 4'b0, 1, o(8'h00, 8'h03, 1, 0, 0));
        @(negedge clk); #1;
        reset_n = 1'b0;
        push_evt(0, z, -1);
        #1;
        n_cmp++;
        if (get_obs(0) !== z) begin
            n_bad++;
            $display("FAIL async_reset: got %h, required %h", get_obs(0), z);
        end
        repeat (2) @(posedge clk); #1;
        reset_n = 1'b1;
        strobe(0, M_START, 8'h00, 8'h00, 0, z);
        tick(0, 4'b0, 0, z);

        // Full countdown to 00:00 with done pulse, then an idle tick
        strobe(0, M_LOAD, 8'h00, 8'h03, 1, o(8'h00, 8'h03, 0, 0, 0));
        strobe(0, M_START, 8'h00, 8'h00, 1, o(8'h00, 8'h03, 1, 0, 0));
        tick(0, 4'b0, 1, o(8'h00, 8'h02, 1, 0, 0));
        tick(0, 4'b0, 1, o(8'h00, 8'h01, 1, 0, 0));
        tick(0, 4'b0, 1, o(8'h00, 8'h00, 0, 1, 0));
        tick(0, 4'b0, 0, z);

        // Borrow chains, load ignored while running, max value
        strobe(0, M_LOAD, 8'h10, 8'h00, 1, o(8'h10, 8'h00, 0, 0, 0));
        strobe(0, M_START, 8'h00, 8'h00, 1, o(8'h10, 8'h00, 1, 0, 0));
        tick(0, 4'b0, 1, o(8'h09, 8'h59, 1, 0, 0));
        strobe(0, M_PAUSE, 8'h00, 8'h00, 1, o(8'h09, 8'h59, 0, 0, 0));
        strobe(0, M_LOAD, 8'h01, 8'h00, 1, o(8'h01, 8'h00, 0, 0, 0));
        strobe(0, M_START, 8'h00, 8'h00, 1, o(8'h01, 8'h00, 1, 0, 0));
        strobe(0, M_LOAD, 8'h00, 8'h07, 0, z);
        tick(0, 4'b0, 1, o(8'h00, 8'h59, 1, 0, 0));
        strobe(0, M_CLEAR, 8'h00, 8'h00, 1, z);
        strobe(0, M_LOAD, 8'h99, 8'h59, 1, o(8'h99, 8'h59, 0, 0, 0));

        // Rejected loads leave the time alone and pulse load_error
        strobe(0, M_LOAD, 8'h99, 8'h60, 1, o(8'h99, 8'h59, 0, 0, 1));
        strobe(0, M_LOAD, 8'h0A, 8'h00, 1, o(8'h99, 8'h59, 0, 0, 1));
        strobe(0, M_START, 8'h00, 8'h00, 1, o(8'h99, 8'h59, 1, 0, 0));
        tick(0, 4'b0, 1, o(8'h99, 8'h58, 1, 0, 0));
        strobe(0, M_CLEAR, 8'h00, 8'h00, 1, z);

        // Pause/start coinciding with sec_pulse, clear beating start
        strobe(0, M_LOAD, 8'h00, 8'h10, 1, o(8'h00, 8'h10, 0, 0, 0));
        strobe(0, M_START, 8'h00, 8'h00, 1, o(8'h00, 8'h10, 1, 0, 0));
        tick(0, M_PAUSE, 1, o(8'h00, 8'h10, 0, 0, 0));
        tick(0, 4'b0, 0, z);
        strobe(0, M_START, 8'h00, 8'h00, 1, o(8'h00, 8'h10, 1, 0, 0));
        tick(0, 4'b0, 1, o(8'h00, 8'h09, 1, 0, 0));
        strobe(0, M_PAUSE, 8'h00, 8'h00, 1, o(8'h00, 8'h09, 0, 0, 0));
        tick(0, M_START, 1, o(8'h00, 8'h09, 1, 0, 0));
        tick(0, 4'b0, 1, o(8'h00, 8'h08, 1, 0, 0));
        strobe(0, M_CLEAR | M_START, 8'h00, 8'h00, 1, z);
        strobe(0, M_START, 8'h00, 8'h00, 0, z);

        // Prescaler of 3 on dut1, held across a pause
        strobe(1, M_LOAD, 8'h00, 8'h02, 1, o(8'h00, 8'h02, 0, 0, 0));
        strobe(1, M_START, 8'h00, 8'h00, 1, o(8'h00, 8'h02, 1, 0, 0));
        tick(1, 4'b0, 0, z);
        strobe(1, M_PAUSE, 8'h00, 8'h00, 1, o(8'h00, 8'h02, 0, 0, 0));
        tick(1, 4'b0, 0, z);
        strobe(1, M_START, 8'h00, 8'h00, 1, o(8'h00, 8'h02, 1, 0, 0));
        tick(1, 4'b0, 0, z);
        tick(1, 4'b0, 1, o(8'h00, 8'h01, 1, 0, 0));
        tick(1, 4'b0, 0, z);
        tick(1, 4'b0, 0, z);
        tick(1, 4'b0, 1, o(8'h00, 8'h00, 0, 1, 0));
        tick(1, 4'b0, 0, z);

`ifdef DOOR_INTERLOCK_EN
        // Door opening pauses a run and blocks start until it closes
        strobe(0, M_LOAD, 8'h00, 8'h05, 1, o(8'h00, 8'h05, 0, 0, 0));
        strobe(0, M_START, 8'h00, 8'h00, 1, o(8'h00, 8'h05, 1, 0, 0));
        @(posedge clk); #1;
        door_s = 1'b1;
        push_evt(0, o(8'h00, 8'h05, 0, 0, 0), cyc + 3);
        repeat (5) @(posedge clk);
        strobe(0, M_START, 8'h00, 8'h00, 0, z);
        #1 door_s = 1'b0;
        repeat (4) @(posedge clk);
        strobe(0, M_START, 8'h00, 8'h00, 1, o(8'h00, 8'h05, 1, 0, 0));
        strobe(0, M_CLEAR, 8'h00, 8'h00, 1, z);
`endif

        repeat (10) @(posedge clk);
        n_cmp++;
        if (q0.size() != 0) begin
            n_bad++;
            $display("FAIL pending_dut0: got %0d outstanding expected changes, required 0", q0.size());
        end
        n_cmp++;
        if (q1.size() != 0) begin
            n_bad++;
            $display("FAIL pending_dut1: got %0d outstanding expected changes, required 0", q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
